sobel_window_master: RTL and testbench

Upstream feeder for `sobel_edge_detector`. It accepts a raster-order 4-bit pixel stream and buffers four image rows in line buffers. It then sweeps 4x4 windows with stride 2 and drives each window into the detector's AHB-style slave port as one write followed by one read request. The four edge pixels returned per window are re-emitted with their image coordinates, forming the hardware replacement for the bench-driven window loop.

---
 rtl/sobel_window_master.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sobel_window_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_master.sv
// sobel_window_master
//
// Feeds a sobel_edge_detector from a raster pixel stream. Four image rows are
// held in a circular line buffer. 4x4 windows are swept with stride 2. Each
// window is sent to the detector as one write request and then one read
// request. The four edge pixels that come back are re-emitted with their
// image coordinates.
//
// Handshakes:
//   pixel in : a pixel is taken on a rising clk edge when pix_valid & pix_ready.
//              pix_ready is high only in FILL and only while n_rst is high.
//   detector : HREADY pulses high for exactly one cycle for each request
//              (HWRITE=1 window write, HWRITE=0 result read). HREADYOUT is the
//              detector's completion / data strobe. It is looked at only while
//              a request is outstanding (WR_WAIT / RD_WAIT).
//   edge out : edge_valid is a one-cycle strobe with no backpressure.
//
// Ports:
//   clk, n_rst           clock, synchronous active-low reset
//   pix_in/pix_valid/pix_ready    raster pixel stream (4-bit)
//   brightness           copied into HWDATA[3:0] when a window is loaded
//   HSEL/HADDR/HTRANS/HSIZE       constant AHB-style control toward detector
//   HWRITE/HWDATA/HREADY          request toward detector
//   HREADYOUT/HRDATA     detector response, HRDATA[3:0] = edge pixel
//   edge_pix/edge_valid/edge_row/edge_col   coordinate-tagged results
//   frame_done           one-cycle pulse after the last result of a frame
//   dbg_state            current FSM state, for observation only
module sobel_window_master #(
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 300
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [3:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [3:0]  brightness,
    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [67:0] HWDATA,
    output logic        HREADY,
    input  logic        HREADYOUT,
    input  logic [67:0] HRDATA,
    output logic [3:0]  edge_pix,
    output logic        edge_valid,
    output logic [8:0]  edge_row,
    output logic [8:0]  edge_col,
    output logic        frame_done,
    output logic [2:0]  dbg_state
);

    localparam int             CW        = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0]  LAST_COL  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]  LAST_WCOL = CW'(IMG_WIDTH - 4);
    localparam logic [8:0]     LAST_WROW = 9'(IMG_HEIGHT - 4);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_ADVANCE = 3'd5
    } state_t;

    state_t         state_q;
    logic [1:0]     top_q;       // physical line-buffer row holding window row 0
    logic [1:0]     fill_row_q;  // window row currently being written
    logic [CW-1:0]  fill_col_q;
    logic [8:0]     win_row_q;
    logic [CW-1:0]  win_col_q;
    logic [1:0]     cap_cnt_q;   // results captured for the current window

    logic           hready_q;
    logic           hwrite_q;
    logic [67:0]    hwdata_q;
    logic [3:0]     edge_pix_q;
    logic           edge_valid_q;
    logic [8:0]     edge_row_q;
    logic [8:0]     edge_col_q;
    logic           frame_done_q;

    logic [3:0]     lb_q [4][IMG_WIDTH];

    logic           pix_acc;
    logic [1:0]     wr_prow;
    logic [CW-1:0]  win_col_d;
    logic [67:0]    win_data_d;
    logic           unused_hrdata;

    assign pix_ready = n_rst & (state_q == S_FILL);
    assign pix_acc   = pix_valid & pix_ready;

    // Window rows map circularly onto the four physical rows.
    assign wr_prow   = top_q + fill_row_q;

    // Column of the window about to be loaded: column 0 when leaving FILL,
    // otherwise the next stride-2 column of the current row pair.
    assign win_col_d = (state_q == S_FILL) ? '0 : win_col_q + CW'(2);

    // ------------------------------------------------------------------
    // Line buffer. No reset: its contents are rewritten before use.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb_q[wr_prow][fill_col_q] <= pix_in;
        end
    end

    // ------------------------------------------------------------------
    // Window assembly. On the edge that accepts the last fill pixel, that
    // pixel is not in the buffer yet, so it is forwarded from pix_in.
    // Pixel (m,n) sits at [67-16m-4n -: 4]; the low nibble is brightness.
    // ------------------------------------------------------------------
    always_comb begin
        win_data_d = '0;
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 4; n++) begin
                if (pix_acc && ((top_q + 2'(m)) == wr_prow) &&
                    ((win_col_d + CW'(n)) == fill_col_q)) begin
                    win_data_d[67-16*m-4*n -: 4] = pix_in;
                end else begin
                    win_data_d[67-16*m-4*n -: 4] =
                        lb_q[top_q + 2'(m)][win_col_d + CW'(n)];
                end
            end
        end
        win_data_d[3:0] = brightness;
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= S_FILL;
            top_q        <= '0;
            fill_row_q   <= '0;
            fill_col_q   <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            cap_cnt_q    <= '0;
            hready_q     <= 1'b0;
            hwrite_q     <= 1'b0;
            hwdata_q     <= '0;
            edge_pix_q   <= '0;
            edge_valid_q <= 1'b0;
            edge_row_q   <= '0;
            edge_col_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // Strobes default low; each is set only on its triggering edge.
            hready_q     <= 1'b0;
            edge_valid_q <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                S_FILL: begin
                    if (pix_acc) begin
                        if (fill_col_q == LAST_COL) begin
                            fill_col_q <= '0;
                            if (fill_row_q == 2'd3) begin
                                state_q   <= S_WR_REQ;
                                win_col_q <= '0;
                                hready_q  <= 1'b1;
                                hwrite_q  <= 1'b1;
                                hwdata_q  <= win_data_d;
                            end else begin
                                fill_row_q <= fill_row_q + 2'd1;
                            end
                        end else begin
                            fill_col_q <= fill_col_q + CW'(1);
                        end
                    end
                end

                S_WR_REQ: begin
                    state_q <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (HREADYOUT) begin
                        state_q  <= S_RD_REQ;
                        hready_q <= 1'b1;
                        hwrite_q <= 1'b0;
                    end
                end

                S_RD_REQ: begin
                    state_q   <= S_RD_WAIT;
                    cap_cnt_q <= '0;
                end

                S_RD_WAIT: begin
                    if (HREADYOUT) begin
                        // Results arrive as (r+1,c+1) (r+1,c+2) (r+2,c+1) (r+2,c+2).
                        edge_valid_q <= 1'b1;
                        edge_pix_q   <= HRDATA[3:0];
                        edge_row_q   <= win_row_q + 9'd1 + 9'(cap_cnt_q[1]);
                        edge_col_q   <= 9'(win_col_q) + 9'd1 + 9'(cap_cnt_q[0]);
                        cap_cnt_q    <= cap_cnt_q + 2'd1;
                        if (cap_cnt_q == 2'd3) begin
                            if (win_col_q == LAST_WCOL) begin
                                state_q <= S_ADVANCE;
                            end else begin
                                state_q   <= S_WR_REQ;
                                win_col_q <= win_col_d;
                                hready_q  <= 1'b1;
                                hwrite_q  <= 1'b1;
                                hwdata_q  <= win_data_d;
                            end
                        end
                    end
                end

                S_ADVANCE: begin
                    state_q   <= S_FILL;
                    win_col_q <= '0;
                    if (win_row_q == LAST_WROW) begin
                        // Frame complete: the next fill loads all four rows.
                        frame_done_q <= 1'b1;
                        win_row_q    <= '0;
                        top_q        <= '0;
                        fill_row_q   <= 2'd0;
                    end else begin
                        // The two oldest rows are retired and refilled as
                        // window rows 2 and 3 of the next row pair.
                        win_row_q  <= win_row_q + 9'd2;
                        top_q      <= top_q + 2'd2;
                        fill_row_q <= 2'd2;
                    end
                end

                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end
    end

    assign HSEL       = 1'b1;
    assign HADDR      = 32'd0;
    assign HTRANS     = 2'b10;
    assign HSIZE      = 3'b000;
    assign HWRITE     = hwrite_q;
    assign HWDATA     = hwdata_q;
    assign HREADY     = hready_q;
    assign edge_pix   = edge_pix_q;
    assign edge_valid = edge_valid_q;
    assign edge_row   = edge_row_q;
    assign edge_col   = edge_col_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

    // Only the low nibble of the detector's read data carries a result.
    assign unused_hrdata = ^HRDATA[67:4];

endmodule

// File: tb/tb_sobel_window_master.sv
// Directed bench for sobel_window_master on an 8x6 image.
module tb_sobel_window_master;

    localparam int W = 8;
    localparam int H = 6;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        n_rst;
    logic [3:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [3:0]  brightness;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [67:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [67:0] HRDATA;
    logic [3:0]  edge_pix;
    logic        edge_valid;
    logic [8:0]  edge_row;
    logic [8:0]  edge_col;
    logic        frame_done;
    logic [2:0]  dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_window_master #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .brightness (brightness),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRDATA     (HRDATA),
        .edge_pix   (edge_pix),
        .edge_valid (edge_valid),
        .edge_row   (edge_row),
        .edge_col   (edge_col),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [21:0] exp_q[$];     // {row, col, pix} per expected edge result
    logic [67:0] wr_exp_q[$];  // expected HWDATA per window write

    int n_checks = 0;
    int n_errors = 0;

    int n_wr, n_rd, n_hready, n_edge, n_fd;
    int last_edge_cyc, fd_cyc;
    logic fd_pix_ready;
    logic hready_prev;

    int wr_stall = 0;
    int rd_win = 0;
    bit hold_after_two = 0;
    bit held = 0;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [67:0] win_exp(input int r, input int c, input logic [3:0] br);
        logic [67:0] v;
        v = '0;
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 4; n++) begin
                v[67-16*m-4*n -: 4] = 4'((r + m) * W + c + n);
            end
        end
        v[3:0] = br;
        return v;
    endfunction

    // ---------------- detector model ----------------
    task automatic serve_write();
        logic [67:0] w0;
        bit stable;
        n_wr++;
        w0 = HWDATA;
        if (wr_exp_q.size() > 0) check("hwdata", w0, wr_exp_q.pop_front());
        else check("wr_expected", 68'(wr_exp_q.size()), 68'd1);
        stable = 1;
        for (int i = 0; i < 2 + wr_stall; i++) begin
            @(negedge clk);
            if (!n_rst) return;
            if (HREADY || !HWRITE || HWDATA !== w0) stable = 0;
        end
        check("wr_hold_stable", 68'(stable), 68'd1);
        wr_stall = 0;
        HREADYOUT = 1'b1;
    endtask

    task automatic serve_read();
        int wait_n;
        n_rd++;
        for (int b = 0; b < 4; b++) begin
            wait_n = (b == 0 || b == 2) ? 2 : 1;
            for (int i = 0; i < wait_n; i++) begin
                @(negedge clk);
                HREADYOUT = 1'b0;
                if (!n_rst) return;
            end
            HREADYOUT = 1'b1;
            HRDATA = {64'hDEAD_BEEF_0BAD_F00D, 4'(5 + 4 * rd_win + b)};
            if (hold_after_two && b == 1) begin
                @(negedge clk);
                HREADYOUT = 1'b0;
                held = 1;
                for (int i = 0; i < 50 && n_rst; i++) @(negedge clk);
                return;
            end
        end
        rd_win++;
    endtask

    initial begin : detector_model
        HREADYOUT = 1'b0;
        HRDATA = '0;
        forever begin
            @(negedge clk);
            HREADYOUT = 1'b0;
            if (n_rst && HREADY) begin
                if (HWRITE) serve_write();
                else serve_read();
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin : monitor
        hready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (HREADY) begin
                n_hready++;
                check("hready_one_cycle", 68'(hready_prev), 68'd0);
            end
            hready_prev = HREADY;
            if (edge_valid) begin
                n_edge++;
                last_edge_cyc = cyc;
                if (exp_q.size() > 0) check("edge", {46'd0, edge_row, edge_col, edge_pix}, 68'(exp_q.pop_front()));
                else check("edge_avail", 68'(exp_q.size()), 68'd1);
            end
            if (frame_done) begin
                n_fd++;
                fd_cyc = cyc;
                fd_pix_ready = pix_ready;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic feed(input int first, input int n, input int budget, output int acc, output int cycles);
        acc = 0;
        cycles = 0;
        while (acc < n && cycles < budget) begin
            @(negedge clk);
            cycles++;
            pix_valid = 1'b1;
            pix_in = 4'(first + acc);
            if (pix_ready) acc++;
        end
    endtask

    task automatic run_frame(input logic [3:0] br, input int stall, input logic [67:0] first_win);
        int acc, cycles, g, w;
        brightness = br;
        wr_stall = stall;
        rd_win = 0;
        n_wr = 0; n_rd = 0; n_hready = 0; n_edge = 0; n_fd = 0;
        exp_q.delete();
        wr_exp_q.delete();
        w = 0;
        for (int r = 0; r <= H - 4; r += 2) begin
            for (int c = 0; c <= W - 4; c += 2) begin
                wr_exp_q.push_back(win_exp(r, c, br));
                for (int i = 0; i < 4; i++) begin
                    exp_q.push_back({9'(r + 1 + i / 2), 9'(c + 1 + i % 2), 4'(5 + 4 * w + i)});
                end
                w++;
            end
        end

        feed(0, 4 * W, 200, acc, cycles);
        check("fill1_cycles", 68'(cycles), 68'd32);
        @(negedge clk);
        pix_valid = 1'b0;
        check("fill1_ready_low", 68'(pix_ready), 68'd0);
        check("wr_req_hready", 68'(HREADY), 68'd1);
        check("wr_req_hwrite", 68'(HWRITE), 68'd1);
        check("wr_req_hwdata", HWDATA, first_win);

        feed(4 * W, 2 * W, 2000, acc, cycles);
        check("fill2_accepts", 68'(acc), 68'd16);
        @(negedge clk);
        pix_valid = 1'b0;
        check("fill2_ready_low", 68'(pix_ready), 68'd0);

        g = 0;
        while (n_fd == 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("frame_done_seen", 68'(n_fd), 68'd1);
        check("writes", 68'(n_wr), 68'd6);
        check("reads", 68'(n_rd), 68'd6);
        check("edges", 68'(n_edge), 68'd24);
        check("hready_pulses", 68'(n_hready), 68'd12);
        check("fd_after_last_edge", 68'(fd_cyc - last_edge_cyc), 68'd1);
        check("fd_pix_ready", 68'(fd_pix_ready), 68'd1);
        check("edge_q_drained", 68'(exp_q.size()), 68'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int acc, cycles, g;
        n_rst = 1'b0;
        pix_valid = 1'b0;
        pix_in = '0;
        brightness = 4'd8;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("rst_hready", 68'(HREADY), 68'd0);
        check("rst_hwrite", 68'(HWRITE), 68'd0);
        check("rst_hwdata", HWDATA, 68'd0);
        check("rst_edge_valid", 68'(edge_valid), 68'd0);
        check("rst_edge_fields", {46'd0, edge_row, edge_col, edge_pix}, 68'd0);
        check("rst_frame_done", 68'(frame_done), 68'd0);
        check("rst_pix_ready", 68'(pix_ready), 68'd0);
        check("hsel", 68'(HSEL), 68'd1);
        check("haddr", 68'(HADDR), 68'd0);
        check("htrans", 68'(HTRANS), 68'd2);
        check("hsize", 68'(HSIZE), 68'd0);
        n_rst = 1'b1;
        n_hready = 0;
        @(negedge clk);
        check("post_rst_pix_ready", 68'(pix_ready), 68'd1);
        repeat (5) @(negedge clk);
        check("idle_no_hready", 68'(n_hready), 68'd0);

        // Packing, read path and full frame.
        run_frame(4'd8, 0, 68'h0123_89AB_0123_89AB_8);

        // Same frame with a 100-cycle write stall and a different brightness.
        run_frame(4'd3, 100, 68'h0123_89AB_0123_89AB_3);

        // Reset in RD_WAIT after two captures.
        exp_q.delete();
        wr_exp_q.delete();
        wr_exp_q.push_back(win_exp(0, 0, 4'd8));
        exp_q.push_back({9'd1, 9'd1, 4'd5});
        exp_q.push_back({9'd1, 9'd2, 4'd6});
        brightness = 4'd8;
        rd_win = 0;
        n_edge = 0;
        held = 0;
        hold_after_two = 1;
        feed(0, 4 * W, 200, acc, cycles);
        @(negedge clk);
        pix_valid = 1'b0;
        g = 0;
        while (!held && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("hold_reached", 68'(held), 68'd1);
        @(negedge clk);
        check("edges_before_rst", 68'(n_edge), 68'd2);
        check("rd_wait_state", 68'(dbg_state), 68'd4);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_hready", 68'(HREADY), 68'd0);
        check("midrst_edge_valid", 68'(edge_valid), 68'd0);
        check("midrst_edge_row", 68'(edge_row), 68'd0);
        check("midrst_state", 68'(dbg_state), 68'd0);
        hold_after_two = 0;
        n_rst = 1'b1;
        n_edge = 0;
        n_hready = 0;
        repeat (10) @(negedge clk);
        check("midrst_no_edges", 68'(n_edge), 68'd0);
        check("midrst_no_hready", 68'(n_hready), 68'd0);

        // Fresh frame after the reset starts again at window (0,0).
        run_frame(4'd8, 0, 68'h0123_89AB_0123_89AB_8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

endmodule
